// File: rtl/uniq_hist_pkg.sv
// Shared types and constants for the round-robin arbiter and its
// move-to-front distinct-value history.
package uniq_hist_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int HIST_DEPTH = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uniq_hist_core.sv
// Four-slot move-to-front history of distinct values: slot 0 is the newest,
// a repeated value is promoted to slot 0 without disturbing older entries.
module uniq_hist_core
    import uniq_hist_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         clear_in,
    input  logic                         push_in,
    input  logic [DATA_W-1:0]            data_in,
    output logic [HIST_DEPTH*DATA_W-1:0] slot_data_out,
    output logic [HIST_DEPTH-1:0]        slot_valid_out
);

    logic [DATA_W-1:0]     slot_q [HIST_DEPTH];
    logic [DATA_W-1:0]     slot_d [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] valid_q;
    logic [HIST_DEPTH-1:0] valid_d;
    logic [HIST_DEPTH-1:0] match;
    logic                  match_above;

    // A slot shifts down only if no slot nearer the front holds the pushed
    // value; on a miss that is every slot, on a hit at k it is slots 1..k.
    always_comb begin
        slot_d      = slot_q;
        valid_d     = valid_q;
        match_above = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            match[i] = valid_q[i] && (slot_q[i] == data_in);
        end
        if (push_in) begin
            for (int i = 1; i < HIST_DEPTH; i++) begin
                match_above = match_above | match[i-1];
                if (!match_above) begin
                    slot_d[i]  = slot_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end
            slot_d[0]  = data_in;
            valid_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || clear_in) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) begin
            slot_data_out[i*DATA_W +: DATA_W] = valid_q[i] ? slot_q[i] : '0;
        end
        slot_valid_out = valid_q;
    end

endmodule

// File: rtl/uniq_hist_arbiter.sv
// Round-robin arbiter feeding a distinct-value history, with pause/flush
// control, last-source tracking and a saturating accept counter.
module uniq_hist_arbiter
    import uniq_hist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 4,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [N_REQ-1:0]        req_valid_in,
    input  logic [N_REQ*DATA_W-1:0] req_data_in,
    output logic [N_REQ-1:0]        req_ready_out,
    input  logic                    flush_in,
    input  logic                    pause_in,
    output logic [DATA_W-1:0]       out_0,
    output logic [DATA_W-1:0]       out_1,
    output logic [DATA_W-1:0]       out_2,
    output logic [DATA_W-1:0]       out_3,
    output logic                    out_valid_0,
    output logic                    out_valid_1,
    output logic                    out_valid_2,
    output logic                    out_valid_3,
    output logic [IW-1:0]           last_src_out,
    output logic [15:0]             accept_cnt_out
);

    state_e                      state_q, state_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]               last_src_q, last_src_d;
    logic [15:0]                 accept_cnt_q, accept_cnt_d;

    logic                        grant_en;
    logic                        found;
    logic [IW-1:0]               gnt_idx;
    logic [N_REQ-1:0]            gnt_oh;
    logic                        accept;
    logic [DATA_W-1:0]           acc_data;
    logic                        hist_clear;
    logic [HIST_DEPTH*DATA_W-1:0] hist_data;
    logic [HIST_DEPTH-1:0]       hist_valid;

    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN:   state_d = pause_in ? ST_PAUSE : ST_RUN;
                ST_PAUSE: state_d = pause_in ? ST_PAUSE : ST_RUN;
                ST_FLUSH: state_d = pause_in ? ST_PAUSE : ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Cyclic search starting one past the last granted requester.
    always_comb begin
        int cand;
        found   = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = 0;
        for (int o = 1; o <= N_REQ; o++) begin
            cand = (int'(rr_ptr_q) + o) % N_REQ;
            if (!found && req_valid_in[cand]) begin
                found        = 1'b1;
                gnt_idx      = IW'(cand);
                gnt_oh[cand] = 1'b1;
            end
        end
    end

    assign grant_en      = (state_q == ST_RUN) && !flush_in && !pause_in && !reset_in;
    assign accept        = grant_en && found;
    assign req_ready_out = accept ? gnt_oh : '0;
    assign acc_data      = req_data_in[int'(gnt_idx)*DATA_W +: DATA_W];
    // Clearing on the flush request edge makes the history read zero
    // during the single ST_FLUSH cycle.
    assign hist_clear    = flush_in || (state_q == ST_FLUSH);

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        last_src_d   = last_src_q;
        accept_cnt_d = accept_cnt_q;
        if (accept) begin
            rr_ptr_d   = gnt_idx;
            last_src_d = gnt_idx;
            if (accept_cnt_q != 16'hFFFF) begin
                accept_cnt_d = accept_cnt_q + 16'd1;
            end
        end
        if (hist_clear) begin
            last_src_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= IW'(N_REQ - 1);
            last_src_q   <= '0;
            accept_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            last_src_q   <= last_src_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    uniq_hist_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .clear_in       (hist_clear),
        .push_in        (accept),
        .data_in        (acc_data),
        .slot_data_out  (hist_data),
        .slot_valid_out (hist_valid)
    );

    assign out_0          = hist_data[0*DATA_W +: DATA_W];
    assign out_1          = hist_data[1*DATA_W +: DATA_W];
    assign out_2          = hist_data[2*DATA_W +: DATA_W];
    assign out_3          = hist_data[3*DATA_W +: DATA_W];
    assign out_valid_0    = hist_valid[0];
    assign out_valid_1    = hist_valid[1];
    assign out_valid_2    = hist_valid[2];
    assign out_valid_3    = hist_valid[3];
    assign last_src_out   = last_src_q;
    assign accept_cnt_out = accept_cnt_q;

endmodule

// File: tb/tb_uniq_hist_arbiter.sv
// Directed bench for uniq_hist_arbiter with hand-computed expectations.
module tb_uniq_hist_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        flush;
    logic        pause;
    logic [7:0]  o0, o1, o2, o3;
    logic        v0, v1, v2, v3;
    logic [1:0]  last_src;
    logic [15:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    uniq_hist_arbiter #(.DATA_W(8), .N_REQ(4)) dut (
        .clk_in         (clk),
        .reset_in       (reset),
        .req_valid_in   (req_valid),
        .req_data_in    (req_data),
        .req_ready_out  (req_ready),
        .flush_in       (flush),
        .pause_in       (pause),
        .out_0          (o0),
        .out_1          (o1),
        .out_2          (o2),
        .out_3          (o3),
        .out_valid_0    (v0),
        .out_valid_1    (v1),
        .out_valid_2    (v2),
        .out_valid_3    (v3),
        .last_src_out   (last_src),
        .accept_cnt_out (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        pause     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One single-requester transfer: grant must be seen, then history updates.
    task automatic send(input int src, input logic [7:0] d, input string tag);
        req_valid = 4'(1 << src);
        req_data[src*8 +: 8] = d;
        #1;
        chk(tag, {28'd0, req_ready}, 32'(1 << src));
        tick();
        req_valid = '0;
    endtask

    task automatic chk_hist(input string tag, input logic [31:0] dat, input logic [3:0] vld);
        chk({tag, "_data"}, {o0, o1, o2, o3}, dat);
        chk({tag, "_vld"}, {28'd0, v0, v1, v2, v3}, {28'd0, vld});
    endtask

    initial begin
        logic [7:0] seq34 [10];
        logic [3:0] exp35 [6];
        seq34 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};
        exp35 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};

        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        flush     = 1'b1;
        pause     = 1'b0;
        tick();
        tick();
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk_hist("rst_hist", 32'd0, 4'b0000);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        chk("rst_last", {30'd0, last_src}, 32'd0);

        // Requester 0: 1 2 1 2 1 2 1
        do_reset();
        for (int i = 0; i < 7; i++) send(0, (i % 2 == 0) ? 8'd1 : 8'd2, "r33_gnt");
        chk_hist("r33", 32'h01020000, 4'b1100);
        chk("r33_cnt", {16'd0, cnt}, 32'd7);
        chk("r33_last", {30'd0, last_src}, 32'd0);

        // Requester 1: move-to-front sequence
        do_reset();
        for (int i = 0; i < 10; i++) send(1, seq34[i], "r34_gnt");
        chk_hist("r34", 32'h04030201, 4'b1111);
        chk("r34_last", {30'd0, last_src}, 32'd1);
        chk("r34_cnt", {16'd0, cnt}, 32'd10);

        // Requesters 0 and 2 contend for 6 cycles
        do_reset();
        req_data  = 32'h00200010;
        req_valid = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("r35_gnt", {28'd0, req_ready}, {28'd0, exp35[i]});
            tick();
        end
        req_valid = '0;
        chk("r35_cnt", {16'd0, cnt}, 32'd6);
        chk_hist("r35", 32'h20100000, 4'b1100);
        chk("r35_last", {30'd0, last_src}, 32'd2);

        // Flush with history full and requester 3 waiting
        do_reset();
        for (int i = 5; i <= 8; i++) send(3, 8'(i), "r36_fill");
        chk_hist("r36_full", 32'h08070605, 4'b1111);
        req_valid = 4'b1000;
        req_data[31:24] = 8'h09;
        flush = 1'b1;
        #1;
        chk("r36_flush_rdy", {28'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk_hist("r36_clr", 32'd0, 4'b0000);
        chk("r36_clr_last", {30'd0, last_src}, 32'd0);
        chk("r36_clr_cnt", {16'd0, cnt}, 32'd4);
        chk("r36_st_rdy", {28'd0, req_ready}, 32'd0);
        tick();
        #1;
        chk("r36_resume", {28'd0, req_ready}, 32'b1000);
        tick();
        req_valid = '0;
        chk_hist("r36_after", 32'h09000000, 4'b1000);
        chk("r36_cnt", {16'd0, cnt}, 32'd5);

        // Pause for 3 cycles with every requester valid (rr_ptr = 3)
        req_data  = 32'h33323130;
        req_valid = 4'hF;
        pause     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r37_pause_rdy", {28'd0, req_ready}, 32'd0);
            tick();
        end
        pause = 1'b0;
        chk_hist("r37_held", 32'h09000000, 4'b1000);
        chk("r37_cnt", {16'd0, cnt}, 32'd5);
        #1;
        chk("r37_rel_rdy", {28'd0, req_ready}, 32'd0);
        tick();
        #1;
        chk("r37_gnt", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid = '0;
        chk_hist("r37_push", 32'h30090000, 4'b1100);

        // Zero is a legal datum; then reset mid-stream
        do_reset();
        send(0, 8'd0, "r38_gnt0");
        chk_hist("r38_zero", 32'h00000000, 4'b1000);
        send(0, 8'd5, "r38_gnt5");
        chk_hist("r38", 32'h05000000, 4'b1100);
        req_valid = 4'b0001;
        req_data[7:0] = 8'h07;
        reset = 1'b1;
        #1;
        chk("r38_rst_rdy", {28'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b0;
        chk_hist("r38_rst", 32'd0, 4'b0000);
        chk("r38_rst_cnt", {16'd0, cnt}, 32'd0);
        #1;
        chk("r38_first", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid = '0;
        chk_hist("r38_post", 32'h07000000, 4'b1000);
        chk("r38_post_cnt", {16'd0, cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uniq_hist_arbiter.md
UNIQ_HIST_ARBITER -- requirements
Module: uniq_hist_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of every data word.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 reset_in  input  1  reset, synchronous and active-high.
REQ-005 req_valid_in  input  N_REQ  per-requester data-valid.
REQ-006 req_data_in  input  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
REQ-007 req_ready_out  output  N_REQ  one-hot-or-zero grant; transfer on valid&ready.
REQ-008 flush_in  input  1  single-cycle clear request for the history.
REQ-009 pause_in  input  1  level; blocks all grants while high.
REQ-010 out_0..out_3  output  DATA_W each  history; out_0 newest distinct value, out_3 oldest.
REQ-011 out_valid_0..out_valid_3  output  1 each  slot-occupied flags.
REQ-012 last_src_out  output  clog2(N_REQ)  index of requester whose datum was last accepted.
REQ-013 accept_cnt_out  output  16  saturating count of accepted transfers.

Function
REQ-014 FSM states ST_RUN, ST_PAUSE, ST_FLUSH; the FSM enters ST_RUN on reset release.
REQ-015 Transitions: any state -> ST_FLUSH when flush_in=1; ST_FLUSH -> ST_PAUSE if pause_in=1, else ST_RUN; ST_RUN <-> ST_PAUSE follow pause_in.
REQ-016 Grants are issued only in ST_RUN with flush_in=0 and pause_in=0; req_ready_out is otherwise all zero.
REQ-017 Arbitration is round-robin: the grant goes to the first requester with valid=1 searching cyclically from (rr_ptr+1); req_ready_out depends combinationally on req_valid_in.
REQ-018 rr_ptr updates to the granted index only on an accepted transfer; rr_ptr is unchanged in idle cycles.
REQ-019 At most one transfer is accepted per cycle.
REQ-020 The history update on the accepted datum D takes effect on the next rising edge, giving 1-cycle latency to the outputs.
REQ-021 If D equals a valid slot k, slots 0..k-1 shift down by one and D is written to slot 0 (move-to-front); valid flags are unchanged.
REQ-022 If D matches no valid slot, all slots shift down (slot 3 is discarded) and D is written to slot 0 with valid=1.
REQ-023 Value 0 is a legal datum; comparisons use valid slots only.
REQ-024 Invalid slots drive data 0 and valid 0.
REQ-025 ST_FLUSH lasts exactly one cycle and clears all slots, valids and last_src_out; it does not clear accept_cnt_out or rr_ptr.
REQ-026 accept_cnt_out increments by 1 per accepted transfer and holds at 16'hFFFF.
REQ-027 last_src_out loads the granted index on each accepted transfer.

Reset
REQ-028 While reset_in=1, all outputs are 0, rr_ptr=N_REQ-1 (requester 0 has first priority), state=ST_RUN, and req_ready_out=0.
REQ-029 reset_in overrides flush_in, pause_in and any in-progress transfer in the same cycle; no transfer is accepted in a reset cycle.
REQ-030 The first transfer can be accepted on the first cycle after reset_in falls.

Structure
REQ-031 Package uniq_hist_pkg holds the FSM state enum, the HIST_DEPTH=4 constant and a function giving the grant-index width.
REQ-032 Sub-module uniq_hist_core implements the 4-slot move-to-front history (push, data, clear -> slots, valids); uniq_hist_arbiter owns the FSM, the arbiter and the counters.

Verification
REQ-033 Requester 0 only sends 1 2 1 2 1 2 1 -> after the last edge: out_0=1, out_1=2, valid=1,1,0,0, accept_cnt_out=7.
REQ-034 Requester 1 only sends 1 2 3 4 3 2 3 4 3 4 -> final out_0..3 = 4,3,2,1, all valid, last_src_out=1.
REQ-035 Requesters 0 and 2 are held valid for 6 cycles after reset -> grants 0,2,0,2,0,2 and accept_cnt_out=6.
REQ-036 flush_in is asserted while requester 3 is valid with history full -> req_ready_out=0 that cycle, all outputs 0 the next cycle, accept_cnt_out unchanged, and grants resume the cycle after.
REQ-037 pause_in is held high for 3 cycles with all requesters valid -> no grants and history held; on release, the grant goes to (rr_ptr+1).
REQ-038 Requester 0 sends data 0 then 5 after reset -> out_0=5, out_1=0, valid=1,1,0,0; reset_in is then pulsed mid-stream -> all outputs 0 the next cycle.
